led_panel_rx: RTL and testbench

//  Receive-side model/monitor of the HUB75-style LED panel interface (panel end of the matrix driver link).

---
 rtl/led_panel_rx.sv | 148 ++++++++++++++
 tb/tb_led_panel_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_panel_rx.sv
// rtl/led_panel_rx.sv - HUB75 panel-side receiver: pin sync, row capture, on-time and protocol checks
module led_panel_rx #(
  parameter int COLS = 32,
  parameter int CH   = 3,
  parameter int ROWW = 3,
  parameter int ONW  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk_in,
  input  logic                 lat_in,
  input  logic                 oe_n_in,
  input  logic [ROWW-1:0]      row_in,
  input  logic [CH-1:0]        data_in,
  input  logic                 err_clr,
  output logic [COLS*CH-1:0]   row_data,
  output logic [ROWW-1:0]      row_idx,
  output logic                 row_valid,
  output logic [ONW-1:0]       on_time,
  output logic                 on_valid,
  output logic [1:0]           state_o,
  output logic                 count_err,
  output logic                 overlap_err,
  output logic                 ghost_err
);

  localparam int W  = COLS * CH;
  localparam int CW = $clog2(COLS) + 1;
  localparam int PW = 3 + ROWW + CH;
  localparam int EW = 3 + ROWW;
  // Pins packed as {sclk, lat, oe_n, row, data}; idle level has only oe_n high.
  localparam logic [PW-1:0] PIN_IDLE  = PW'(1) << (ROWW + CH);
  localparam logic [EW-1:0] EDGE_IDLE = EW'(1) << ROWW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HELD  = 2'd2,
    SHOW  = 2'd3
  } state_t;

  state_t          state;
  logic [PW-1:0]   pin_q1;
  logic [PW-1:0]   pin_s;
  logic [EW-1:0]   edge_q;
  logic [W-1:0]    shreg;
  logic [W-1:0]    shreg_shift;
  logic [CW-1:0]   shift_cnt;
  logic [CW-1:0]   cnt_inc;
  logic [CW-1:0]   cnt_post;
  logic [CW-1:0]   cnt_next;
  logic [ONW-1:0]  on_cnt;

  logic [CH-1:0]   data_s;
  logic [ROWW-1:0] row_s;
  logic [ROWW-1:0] row_d;
  logic            oe_n_s, oe_n_d, lat_s, lat_d, sclk_s, sclk_d;
  logic            sclk_rise, lat_rise, oe_fall, oe_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pin_q1 <= PIN_IDLE;
      pin_s  <= PIN_IDLE;
      edge_q <= EDGE_IDLE;
    end else begin
      pin_q1 <= {sclk_in, lat_in, oe_n_in, row_in, data_in};
      pin_s  <= pin_q1;
      edge_q <= pin_s[PW-1:CH];
    end
  end

  assign data_s = pin_s[CH-1:0];
  assign row_s  = pin_s[CH+ROWW-1:CH];
  assign oe_n_s = pin_s[CH+ROWW];
  assign lat_s  = pin_s[CH+ROWW+1];
  assign sclk_s = pin_s[CH+ROWW+2];
  assign row_d  = edge_q[ROWW-1:0];
  assign oe_n_d = edge_q[ROWW];
  assign lat_d  = edge_q[ROWW+1];
  assign sclk_d = edge_q[ROWW+2];

  assign sclk_rise = sclk_s & ~sclk_d;
  assign lat_rise  = lat_s & ~lat_d;
  assign oe_fall   = ~oe_n_s & oe_n_d;
  assign oe_rise   = oe_n_s & ~oe_n_d;

  // A bit shifted in the latch cycle is counted and captured, then the count restarts.
  assign shreg_shift = {shreg[W-CH-1:0], data_s};
  assign cnt_inc     = (shift_cnt == {CW{1'b1}}) ? shift_cnt : shift_cnt + CW'(1);
  assign cnt_post    = sclk_rise ? cnt_inc : shift_cnt;
  assign cnt_next    = lat_rise ? '0 : cnt_post;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg       <= '0;
      shift_cnt   <= '0;
      row_data    <= '0;
      row_idx     <= '0;
      row_valid   <= 1'b0;
      on_cnt      <= '0;
      on_time     <= '0;
      on_valid    <= 1'b0;
      count_err   <= 1'b0;
      overlap_err <= 1'b0;
      ghost_err   <= 1'b0;
    end else begin
      row_valid <= 1'b0;
      on_valid  <= 1'b0;
      if (sclk_rise) begin
        shreg <= shreg_shift;
      end
      shift_cnt <= cnt_next;
      if (lat_rise) begin
        row_data  <= sclk_rise ? shreg_shift : shreg;
        row_idx   <= row_s;
        row_valid <= 1'b1;
      end
      if (oe_rise) begin
        on_time  <= on_cnt;
        on_valid <= 1'b1;
        on_cnt   <= '0;
      end else if (!oe_n_s && on_cnt != {ONW{1'b1}}) begin
        on_cnt <= on_cnt + ONW'(1);
      end
      count_err   <= (lat_rise && cnt_post != CW'(COLS)) | (count_err & ~err_clr);
      overlap_err <= (lat_s & ~oe_n_s) | (overlap_err & ~err_clr);
      ghost_err   <= (~oe_n_s & (row_s != row_d)) | (ghost_err & ~err_clr);
    end
  end

  // OE_n edges outrank LAT, which outranks SCLK, for the state decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (oe_fall) begin
      state <= SHOW;
    end else if (oe_rise && state == SHOW) begin
      state <= (cnt_next != '0) ? SHIFT : IDLE;
    end else if (lat_rise) begin
      if (state != SHOW) state <= HELD;
    end else if (sclk_rise) begin
      if (state != SHOW) state <= SHIFT;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_led_panel_rx.sv
// tb/tb_led_panel_rx.sv - randomized and directed bench for led_panel_rx against a pixel-queue model
module tb_led_panel_rx;

  localparam int COLS = 32;
  localparam int CH   = 3;
  localparam int ROWW = 3;
  localparam int ONW  = 16;
  localparam int W    = COLS * CH;
  localparam int CMAX = 63;
  localparam logic [8:0] PIN_IDLE = 9'b001_000_000;

  logic            clk = 1'b0;
  logic            rst;
  logic            sclk_in, lat_in, oe_n_in, err_clr;
  logic [ROWW-1:0] row_in;
  logic [CH-1:0]   data_in;
  logic [W-1:0]    row_data;
  logic [ROWW-1:0] row_idx;
  logic            row_valid, on_valid, count_err, overlap_err, ghost_err;
  logic [ONW-1:0]  on_time;
  logic [1:0]      state_o;

  int checks = 0;
  int errors = 0;

  led_panel_rx #(.COLS(COLS), .CH(CH), .ROWW(ROWW), .ONW(ONW)) dut (
    .clk(clk), .rst(rst), .sclk_in(sclk_in), .lat_in(lat_in), .oe_n_in(oe_n_in),
    .row_in(row_in), .data_in(data_in), .err_clr(err_clr),
    .row_data(row_data), .row_idx(row_idx), .row_valid(row_valid),
    .on_time(on_time), .on_valid(on_valid), .state_o(state_o),
    .count_err(count_err), .overlap_err(overlap_err), .ghost_err(ghost_err)
  );

  always #5 clk = ~clk;

  // Model: pins are seen two clocks late; pixels kept as a queue, newest at the back.
  logic [8:0]      hist[$];
  logic [CH-1:0]   pix[$];
  logic [W-1:0]    m_row_data;
  logic [ROWW-1:0] m_row_idx;
  logic            m_row_valid, m_on_valid, m_cerr, m_oerr, m_gerr;
  logic [ONW-1:0]  m_on_time;
  int              m_state, m_cnt, m_on;

  function automatic logic [W-1:0] build_row();
    logic [W-1:0] r = '0;
    for (int j = 0; j < COLS; j++)
      if (j < pix.size()) r[j*CH +: CH] = pix[pix.size()-1-j];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist = {PIN_IDLE, PIN_IDLE, PIN_IDLE};
      pix.delete();
      m_row_data = '0; m_row_idx = '0; m_row_valid = 0; m_on_valid = 0;
      m_on_time = '0; m_cerr = 0; m_oerr = 0; m_gerr = 0;
      m_state = 0; m_cnt = 0; m_on = 0;
    end else begin
      logic [8:0] cur, prv;
      logic sr, lr, of, orr;
      int post;
      hist.push_back({sclk_in, lat_in, oe_n_in, row_in, data_in});
      cur = hist[hist.size()-3];
      prv = hist[hist.size()-4];
      void'(hist.pop_front());
      sr  = cur[8] && !prv[8];
      lr  = cur[7] && !prv[7];
      of  = !cur[6] && prv[6];
      orr = cur[6] && !prv[6];
      m_row_valid = 0;
      m_on_valid  = 0;
      post = m_cnt;
      if (sr) begin
        pix.push_back(cur[2:0]);
        if (pix.size() > COLS) void'(pix.pop_front());
        post = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      end
      m_cnt = post;
      if (lr) begin
        m_row_data  = build_row();
        m_row_idx   = cur[5:3];
        m_row_valid = 1;
        m_cnt = 0;
      end
      if (orr) begin
        m_on_time = ONW'(m_on);
        m_on_valid = 1;
        m_on = 0;
      end else if (!cur[6] && m_on < 65535) begin
        m_on++;
      end
      m_cerr = (lr && post != COLS) || (m_cerr && !err_clr);
      m_oerr = (cur[7] && !cur[6]) || (m_oerr && !err_clr);
      m_gerr = (!cur[6] && cur[5:3] != prv[5:3]) || (m_gerr && !err_clr);
      if (of) m_state = 3;
      else if (orr && m_state == 3) m_state = (m_cnt > 0) ? 1 : 0;
      else if (lr) begin if (m_state != 3) m_state = 2; end
      else if (sr) begin if (m_state != 3) m_state = 1; end
    end
  end

  int           rv_cnt = 0, ov_cnt = 0;
  logic [W-1:0] cap_row;
  logic [2:0]   cap_idx;
  logic [15:0]  cap_on;

  always begin
    @(posedge clk);
    #2;
    checks++;
    if ({row_data, row_idx, row_valid, on_time, on_valid, state_o, count_err, overlap_err, ghost_err} !==
        {m_row_data, m_row_idx, m_row_valid, m_on_time, m_on_valid, 2'(m_state), m_cerr, m_oerr, m_gerr}) begin
      errors++;
      $display("FAIL model t=%0t got row=%h idx=%0d rv=%b on=%0d ov=%b st=%0d err=%b%b%b need row=%h idx=%0d rv=%b on=%0d ov=%b st=%0d err=%b%b%b",
               $time, row_data, row_idx, row_valid, on_time, on_valid, state_o, count_err, overlap_err, ghost_err,
               m_row_data, m_row_idx, m_row_valid, m_on_time, m_on_valid, m_state, m_cerr, m_oerr, m_gerr);
    end
    if (row_valid) begin rv_cnt++; cap_row = row_data; cap_idx = row_idx; end
    if (on_valid)  begin ov_cnt++; cap_on = on_time; end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sclk_pulse(input logic [2:0] d);
    data_in = d; sclk_in = 1'b1; step(2);
    sclk_in = 1'b0; step(2);
  endtask

  task automatic lat_pulse();
    lat_in = 1'b1; step(2);
    lat_in = 1'b0; step(2);
  endtask

  task automatic clear_errs();
    err_clr = 1'b1; step(1);
    err_clr = 1'b0; step(1);
  endtask

  logic [W-1:0] exp_row;
  logic [2:0]   px [COLS];
  int           rv0, ov0;

  initial begin
    rst = 1'b1; sclk_in = 0; lat_in = 0; oe_n_in = 1; err_clr = 0; row_in = '0; data_in = '0;
    step(3);
    chk("reset_row_data", 128'(row_data), 128'(0));
    chk("reset_state", 128'(state_o), 128'(0));
    chk("reset_pulses", 128'({row_valid, on_valid, on_time}), 128'(0));
    rst = 1'b0; step(2);

    row_in = 3'd5;
    repeat (32) sclk_pulse(3'b101);
    lat_pulse(); step(4);
    exp_row = {32{3'b101}};
    chk("t1_rv_count", 128'(rv_cnt), 128'(1));
    chk("t1_row_data", 128'(cap_row), 128'(exp_row));
    chk("t1_row_idx", 128'(cap_idx), 128'(5));
    chk("t1_count_err", 128'(count_err), 128'(0));
    chk("t1_state_held", 128'(state_o), 128'(2));

    repeat (31) sclk_pulse(3'b101);
    lat_pulse(); step(4);
    chk("t2_rv_count", 128'(rv_cnt), 128'(2));
    chk("t2_count_err_31", 128'(count_err), 128'(1));
    clear_errs();
    chk("t2_err_clr", 128'(count_err), 128'(0));
    repeat (33) sclk_pulse(3'b101);
    lat_pulse(); step(4);
    chk("t2_count_err_33", 128'(count_err), 128'(1));
    clear_errs();

    ov0 = ov_cnt;
    oe_n_in = 1'b0; step(1000);
    oe_n_in = 1'b1; step(6);
    chk("t3_on_valid_count", 128'(ov_cnt - ov0), 128'(1));
    chk("t3_on_time", 128'(cap_on), 128'(1000));
    chk("t3_state_idle", 128'(state_o), 128'(0));

    rv0 = rv_cnt;
    oe_n_in = 1'b0; step(4);
    lat_pulse(); step(2);
    chk("t4_overlap_err", 128'(overlap_err), 128'(1));
    chk("t4_row_valid", 128'(rv_cnt - rv0), 128'(1));
    chk("t4_ghost_quiet", 128'(ghost_err), 128'(0));
    row_in = 3'd2; step(4);
    chk("t4_ghost_err", 128'(ghost_err), 128'(1));
    oe_n_in = 1'b1; step(6);
    clear_errs();

    for (int i = 0; i < COLS; i++) px[i] = 3'($urandom);
    for (int i = 0; i < COLS-1; i++) sclk_pulse(px[i]);
    data_in = px[COLS-1]; sclk_in = 1'b1; lat_in = 1'b1; step(2);
    sclk_in = 1'b0; lat_in = 1'b0; step(6);
    for (int j = 0; j < COLS; j++) exp_row[j*CH +: CH] = px[COLS-1-j];
    chk("t5_row_data", 128'(cap_row), 128'(exp_row));
    chk("t5_count_err", 128'(count_err), 128'(0));
    chk("t5_state_held", 128'(state_o), 128'(2));
    lat_pulse(); step(4);
    chk("t5_cnt_zero_after", 128'(count_err), 128'(1));
    clear_errs();

    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        oe_n_in = ~oe_n_in;
      end else begin
        if ($urandom_range(0, 2) == 0) sclk_in = ~sclk_in;
        if ($urandom_range(0, 5) == 0) lat_in = ~lat_in;
        if ($urandom_range(0, 7) == 0) row_in = 3'($urandom);
        data_in = 3'($urandom);
        err_clr = ($urandom_range(0, 7) == 0);
      end
      step(1);
      err_clr = 1'b0;
      step(1);
    end
    sclk_in = 0; lat_in = 0; oe_n_in = 1; step(10);

    rv0 = rv_cnt; ov0 = ov_cnt;
    oe_n_in = 1'b0;
    repeat (10) sclk_pulse(3'($urandom));
    rst = 1'b1; oe_n_in = 1'b1; step(2);
    chk("t6_reset_row_data", 128'(row_data), 128'(0));
    chk("t6_reset_state", 128'(state_o), 128'(0));
    chk("t6_reset_flags", 128'({count_err, overlap_err, ghost_err, row_idx, on_time}), 128'(0));
    rst = 1'b0; step(10);
    chk("t6_no_pulses", 128'({rv_cnt - rv0, ov_cnt - ov0}), 128'(0));
    chk("t6_idle_after", 128'({state_o, on_time}), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
